n64_send_console_command: RTL and testbench

Console-side transmitter for the N64 joybus single-wire protocol. It serialises a 1–3 byte console command, MSB first, onto the open-drain `n64d` line and ends it with a console stop bit. It sits in front of `n64_receive_controller_data`: it issues the poll (0x01) or status (0x00) request, then releases the line so the controller's reply can be captured.

---
 rtl/n64_pkg.sv | 17 +
 rtl/n64_tx_bit_timer.sv | 37 +++
 rtl/n64_send_console_command.sv | 113 +++++++++++
 tb/tb_n64_send_console_command.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/n64_pkg.sv
// Shared joybus definitions: transmitter state encoding, console command bytes and default timing.
package n64_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_STOP_LOW
  } n64_tx_state_t;

  localparam logic [7:0] N64_CMD_STATUS = 8'h00;
  localparam logic [7:0] N64_CMD_POLL   = 8'h01;
  localparam logic [7:0] N64_CMD_RESET  = 8'hFF;

  localparam int N64_US_CYCLES_DEFAULT = 50;

endpackage

// File: rtl/n64_tx_bit_timer.sv
// Joybus bit phase timer: flags the last cycle of the low/high phase of the current bit value.
// Boundaries are combinational from the phase counter; go restarts the phase, run lets it advance.
module n64_tx_bit_timer
  import n64_pkg::*;
#(
  parameter int US_CYCLES = N64_US_CYCLES_DEFAULT
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic go,
  input  logic run,
  input  logic bit_val,
  output logic low_end,
  output logic high_end
);

  localparam int TW = $clog2(3 * US_CYCLES + 1);
  localparam logic [TW-1:0] SHORT_LAST = TW'(US_CYCLES - 1);
  localparam logic [TW-1:0] LONG_LAST  = TW'(3 * US_CYCLES - 1);

  logic [TW-1:0] phase_cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      phase_cnt <= '0;
    end else if (go) begin
      phase_cnt <= '0;
    end else if (run) begin
      phase_cnt <= phase_cnt + TW'(1);
    end
  end

  // A 1 is short-low/long-high, a 0 is the mirror image.
  assign low_end  = (phase_cnt == (bit_val ? SHORT_LAST : LONG_LAST));
  assign high_end = (phase_cnt == (bit_val ? LONG_LAST : SHORT_LAST));

endmodule

// File: rtl/n64_send_console_command.sv
// Joybus console command transmitter, 1-3 bytes MSB first plus stop bit; drives on the accept edge.
// start ignored while busy; optional rx_trigger pulse with done under N64_TX_RX_TRIGGER_EN.
module n64_send_console_command
  import n64_pkg::*;
#(
  parameter int US_CYCLES = N64_US_CYCLES_DEFAULT
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic [23:0] cmd_data,
  input  logic [1:0]  cmd_len,
  output logic        n64d_oe,
  output logic        busy,
  output logic        done
`ifdef N64_TX_RX_TRIGGER_EN
  ,
  output logic        rx_trigger
`endif
);

  n64_tx_state_t state;
  logic [23:0]   shreg;
  logic [4:0]    bit_cnt;
  logic          accept;
  logic          phase_done;
  logic          low_end;
  logic          high_end;
  logic          bit_val;

  assign accept  = (state == ST_IDLE) && start && (cmd_len != 2'd0);
  // The stop bit is timed as the low phase of a 1.
  assign bit_val = (state == ST_STOP_LOW) | shreg[23];

  always_comb begin
    phase_done = 1'b0;
    case (state)
      ST_BIT_LOW:  phase_done = low_end;
      ST_BIT_HIGH: phase_done = high_end;
      ST_STOP_LOW: phase_done = low_end;
      default:     phase_done = 1'b0;
    endcase
  end

  n64_tx_bit_timer #(
    .US_CYCLES(US_CYCLES)
  ) u_bit_timer (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .go       (accept | phase_done),
    .run      (state != ST_IDLE),
    .bit_val  (bit_val),
    .low_end  (low_end),
    .high_end (high_end)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      n64d_oe    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef N64_TX_RX_TRIGGER_EN
      rx_trigger <= 1'b0;
`endif
    end else begin
      done       <= 1'b0;
`ifdef N64_TX_RX_TRIGGER_EN
      rx_trigger <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shreg   <= cmd_data;
            bit_cnt <= {cmd_len, 3'b000};
            n64d_oe <= 1'b1;
            busy    <= 1'b1;
            state   <= ST_BIT_LOW;
          end
        end
        ST_BIT_LOW: begin
          if (low_end) begin
            n64d_oe <= 1'b0;
            state   <= ST_BIT_HIGH;
          end
        end
        ST_BIT_HIGH: begin
          if (high_end) begin
            shreg   <= {shreg[22:0], 1'b0};
            bit_cnt <= bit_cnt - 5'd1;
            n64d_oe <= 1'b1;
            state   <= (bit_cnt == 5'd1) ? ST_STOP_LOW : ST_BIT_LOW;
          end
        end
        ST_STOP_LOW: begin
          if (low_end) begin
            n64d_oe    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
`ifdef N64_TX_RX_TRIGGER_EN
            rx_trigger <= 1'b1;
`endif
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_n64_send_console_command.sv
// Directed bench for n64_send_console_command: pulse widths, decoded bits, done timing, reset and start handling.
module tb_n64_send_console_command;
  import n64_pkg::*;

  localparam int US = 50;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start     = 1'b0;
  logic [23:0] cmd_data  = '0;
  logic [1:0]  cmd_len   = '0;
  logic        n64d_oe;
  logic        busy;
  logic        done;
`ifdef N64_TX_RX_TRIGGER_EN
  logic        rx_trigger;
`endif

  int total = 0;
  int bad   = 0;

  int runs[$];
  int done_idx;
  int done_cnt;
  int trig_bad;

  always #10 sys_clk = ~sys_clk;

  n64_send_console_command #(
    .US_CYCLES(US)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .cmd_data  (cmd_data),
    .cmd_len   (cmd_len),
    .n64d_oe   (n64d_oe),
    .busy      (busy),
    .done      (done)
`ifdef N64_TX_RX_TRIGGER_EN
    ,
    .rx_trigger(rx_trigger)
`endif
  );

  task automatic launch(input logic [23:0] data, input logic [1:0] len);
    @(negedge sys_clk);
    cmd_data = data;
    cmd_len  = len;
    start    = 1'b1;
  endtask

  // Sample i reflects the state after the i-th edge following the accept edge.
  task automatic capture(input int limit, input int restart_at);
    logic prev;
    prev     = 1'b0;
    runs.delete();
    done_idx = -1;
    done_cnt = 0;
    trig_bad = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge sys_clk);
      if (i == 0) start = 1'b0;
      if (i == restart_at) start = 1'b1;
      if (i == restart_at + 1) start = 1'b0;
`ifdef N64_TX_RX_TRIGGER_EN
      if (rx_trigger !== done) trig_bad++;
`endif
      if (done === 1'b1) begin
        done_cnt++;
        if (done_idx < 0) done_idx = i;
      end
      if (done_idx < 0) begin
        if (runs.size() == 0 || n64d_oe !== prev) runs.push_back(1);
        else runs[runs.size()-1] = runs[runs.size()-1] + 1;
        prev = n64d_oe;
      end
      if (done_idx >= 0 && i >= done_idx + 3) break;
    end
  endtask

  // Bits recovered from low-phase widths, first bit ends up most significant.
  function automatic logic [23:0] decode_runs();
    logic [23:0] w;
    w = '0;
    for (int b = 0; b < (runs.size() - 1) / 2; b++)
      w = {w[22:0], (runs[2*b] < 2*US)};
    return w;
  endfunction

  function automatic int width_errors(input logic [23:0] exp, input int nbits);
    int   errs;
    logic b;
    if (runs.size() != 2*nbits + 1) return 99;
    errs = 0;
    for (int k = 0; k < nbits; k++) begin
      b = exp[nbits-1-k];
      if (runs[2*k]   != (b ? US : 3*US)) errs++;
      if (runs[2*k+1] != (b ? 3*US : US)) errs++;
    end
    if (runs[2*nbits] != US) errs++;
    return errs;
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge sys_clk);
    total++; if (n64d_oe !== 1'b0) begin bad++; $display("FAIL reset_oe got=%b want=0", n64d_oe); end
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0)    begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_len_zero();
    int seen_busy, seen_oe, seen_done;
    seen_busy = 0; seen_oe = 0; seen_done = 0;
    launch(24'h01_0000, 2'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge sys_clk);
      if (i == 3) start = 1'b0;
      if (busy !== 1'b0)    seen_busy++;
      if (n64d_oe !== 1'b0) seen_oe++;
      if (done !== 1'b0)    seen_done++;
    end
    total++; if (seen_busy != 0) begin bad++; $display("FAIL len0_busy cycles=%0d want=0", seen_busy); end
    total++; if (seen_oe != 0)   begin bad++; $display("FAIL len0_oe cycles=%0d want=0", seen_oe); end
    total++; if (seen_done != 0) begin bad++; $display("FAIL len0_done cycles=%0d want=0", seen_done); end
  endtask

  task automatic test_poll();
    launch({N64_CMD_POLL, 16'h0000}, 2'd1);
    capture(2000, -1);
    total++; if (runs.size() != 17) begin bad++; $display("FAIL poll_runs got=%0d want=17", runs.size()); end
    total++; if (decode_runs() !== 24'h000001) begin bad++; $display("FAIL poll_bits got=%h want=000001", decode_runs()); end
    total++; if (width_errors(24'h000001, 8) != 0) begin bad++; $display("FAIL poll_widths errors=%0d want=0", width_errors(24'h000001, 8)); end
    total++; if (done_idx != 1650) begin bad++; $display("FAIL poll_done_time got=%0d want=1650", done_idx); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL poll_done_pulses got=%0d want=1", done_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL poll_busy_after got=%b want=0", busy); end
`ifdef N64_TX_RX_TRIGGER_EN
    total++; if (trig_bad != 0) begin bad++; $display("FAIL poll_rx_trigger mismatched_cycles=%0d want=0", trig_bad); end
`endif
  endtask

  task automatic test_three_byte();
    launch(24'h02_80_01, 2'd3);
    capture(5200, -1);
    total++; if (runs.size() != 49) begin bad++; $display("FAIL b3_runs got=%0d want=49", runs.size()); end
    total++; if (decode_runs() !== 24'h028001) begin bad++; $display("FAIL b3_bits got=%h want=028001", decode_runs()); end
    total++; if (width_errors(24'h028001, 24) != 0) begin bad++; $display("FAIL b3_widths errors=%0d want=0", width_errors(24'h028001, 24)); end
    total++; if (done_idx != 4850) begin bad++; $display("FAIL b3_done_time got=%0d want=4850", done_idx); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL b3_done_pulses got=%0d want=1", done_cnt); end
  endtask

  task automatic test_restart_ignored();
    launch({N64_CMD_POLL, 16'h0000}, 2'd1);
    capture(2000, 500);
    total++; if (runs.size() != 17) begin bad++; $display("FAIL restart_runs got=%0d want=17", runs.size()); end
    total++; if (width_errors(24'h000001, 8) != 0) begin bad++; $display("FAIL restart_widths errors=%0d want=0", width_errors(24'h000001, 8)); end
    total++; if (done_idx != 1650) begin bad++; $display("FAIL restart_done_time got=%0d want=1650", done_idx); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL restart_done_pulses got=%0d want=1", done_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    int seen_done, seen_oe;
    seen_done = 0; seen_oe = 0;
    launch({N64_CMD_POLL, 16'h0000}, 2'd1);
    for (int i = 0; i < 300; i++) begin
      @(negedge sys_clk);
      if (i == 0) start = 1'b0;
    end
    total++; if (n64d_oe !== 1'b1) begin bad++; $display("FAIL rst_mid_pre_oe got=%b want=1", n64d_oe); end
    #3 sys_rst_n = 1'b0;
    #1;
    total++; if (n64d_oe !== 1'b0) begin bad++; $display("FAIL rst_mid_oe got=%b want=0", n64d_oe); end
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge sys_clk);
      if (done !== 1'b0)    seen_done++;
      if (n64d_oe !== 1'b0) seen_oe++;
    end
    total++; if (seen_done != 0) begin bad++; $display("FAIL rst_mid_done cycles=%0d want=0", seen_done); end
    total++; if (seen_oe != 0)   begin bad++; $display("FAIL rst_mid_idle_oe cycles=%0d want=0", seen_oe); end
    launch({N64_CMD_POLL, 16'h0000}, 2'd1);
    capture(2000, -1);
    total++; if (width_errors(24'h000001, 8) != 0) begin bad++; $display("FAIL rst_new_widths errors=%0d want=0", width_errors(24'h000001, 8)); end
    total++; if (done_idx != 1650) begin bad++; $display("FAIL rst_new_done_time got=%0d want=1650", done_idx); end
  endtask

  task automatic test_back_to_back();
    int   d1, d2;
    logic oe_at_d1, busy_at_d1, oe_after, busy_after;
    d1 = -1; d2 = -1;
    oe_at_d1 = 1'bx; busy_at_d1 = 1'bx; oe_after = 1'bx; busy_after = 1'bx;
    launch({N64_CMD_STATUS, 16'h0000}, 2'd1);
    for (int i = 0; i < 4000; i++) begin
      @(negedge sys_clk);
      if (d1 >= 0 && i == d1 + 1) begin oe_after = n64d_oe; busy_after = busy; end
      if (done === 1'b1) begin
        if (d1 < 0) begin d1 = i; oe_at_d1 = n64d_oe; busy_at_d1 = busy; end
        else begin d2 = i; start = 1'b0; break; end
      end
    end
    start = 1'b0;
    total++; if (d1 != 1650) begin bad++; $display("FAIL b2b_done1 got=%0d want=1650", d1); end
    total++; if (oe_at_d1 !== 1'b0 || busy_at_d1 !== 1'b0) begin bad++; $display("FAIL b2b_done_edge oe=%b busy=%b want=0/0", oe_at_d1, busy_at_d1); end
    total++; if (oe_after !== 1'b1 || busy_after !== 1'b1) begin bad++; $display("FAIL b2b_reaccept oe=%b busy=%b want=1/1", oe_after, busy_after); end
    total++; if (d2 != 3301) begin bad++; $display("FAIL b2b_done2 got=%0d want=3301", d2); end
    repeat (3) @(negedge sys_clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_busy got=%b want=0", busy); end
  endtask

  initial begin
    test_reset();
    test_len_zero();
    test_poll();
    test_three_byte();
    test_restart_ignored();
    test_reset_mid_frame();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
